// File: rtl/axis_arb_mux_2to1.sv
// Packet-aware 2:1 AXI-Stream arbiter and mux; a grant covers a whole packet, last=1 beat included.
// Latency: one arbitration cycle before each packet's first beat, then a zero-cycle combinational path.
// Backpressure: sink ready passes straight to the granted source only; the other source sees ready=0.
module axis_arb_mux_2to1 #(
   parameter int WIDTH       = 4,
   parameter int ROUND_ROBIN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_0,
   input  logic             last_0,
   input  logic             valid_0,
   output logic             ready_0,
   input  logic [WIDTH-1:0] data_1,
   input  logic             last_1,
   input  logic             valid_1,
   output logic             ready_1,
   output logic [WIDTH-1:0] data,
   output logic             last,
   output logic             valid,
   input  logic             ready,
   output logic             sel,
   output logic             busy
);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_grant;
   logic             w_grant_nxt;
   logic             r_last_grant;
   logic             w_last_grant_nxt;

   // Granted-port view of the upstream signals, shared by the FSM and the output mux.
   logic [WIDTH-1:0] w_data_g;
   logic             w_last_g;
   logic             w_valid_g;
   logic             w_xfer;
   logic             w_active;

   assign w_data_g  = r_grant ? data_1  : data_0;
   assign w_last_g  = r_grant ? last_1  : last_0;
   assign w_valid_g = r_grant ? valid_1 : valid_0;
   assign w_xfer    = (r_state == S_BUSY) && w_valid_g && ready;
   // Reset forces the handshake outputs low at once, even while the state register still says BUSY.
   assign w_active  = (r_state == S_BUSY) && !rst;

   // State register: IDLE with port 0 favoured on the first tie after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_last_grant <= w_last_grant_nxt;
      end
   end

   // Next state: arbitrate in IDLE, hold the grant in BUSY until a last beat actually transfers.
   always_comb begin
      w_state_nxt      = r_state;
      w_grant_nxt      = r_grant;
      w_last_grant_nxt = r_last_grant;
      case (r_state)
         S_IDLE: begin
            if (valid_0 && valid_1) begin
               w_grant_nxt = (ROUND_ROBIN != 0) ? ~r_last_grant : 1'b0;
               w_state_nxt = S_BUSY;
            end else if (valid_0) begin
               w_grant_nxt = 1'b0;
               w_state_nxt = S_BUSY;
            end else if (valid_1) begin
               w_grant_nxt = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (w_xfer && w_last_g) begin
               w_last_grant_nxt = r_grant;
               w_state_nxt      = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs: data/last always follow the grant; handshakes only open while a packet grant is held.
   always_comb begin
      data    = w_data_g;
      last    = w_last_g;
      valid   = w_active && w_valid_g;
      ready_0 = w_active && !r_grant && ready;
      ready_1 = w_active && r_grant && ready;
      busy    = w_active;
      sel     = rst ? 1'b0 : r_grant;
   end

endmodule
